// File: rtl/reservation_station_pkg.sv
// Shared types for the reservation station: scheduler bundle and state enum.
package reservation_station_pkg;

    localparam int ROB_TAG_W = 4;
    localparam int XLEN      = 32;
    localparam int ALU_OP_W  = 3;
    localparam int BR_TYPE_W = 2;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        WAITING = 2'd1,
        READY   = 2'd2
    } rs_state_t;

    typedef struct packed {
        logic                 valid_operands;
        logic [ALU_OP_W-1:0]  ALU_op;
        logic [ROB_TAG_W-1:0] ROB_entry;
        logic [BR_TYPE_W-1:0] branch_type;
        logic [XLEN-1:0]      rs1;
        logic [XLEN-1:0]      rs2;
    } rs_out_t;

endpackage

// File: rtl/rs_operand_slot.sv
// One source operand: value/ready/tag storage plus N_CDB-way tag snoop.
module rs_operand_slot
    import reservation_station_pkg::*;
#(
    parameter int N_CDB = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       load,
    input  logic                       snoop,
    input  logic [XLEN-1:0]            load_val,
    input  logic                       load_rdy,
    input  logic [ROB_TAG_W-1:0]       load_tag,
    input  logic [N_CDB-1:0]           cdb_valid,
    input  logic [ROB_TAG_W*N_CDB-1:0] cdb_rob_entry,
    input  logic [XLEN*N_CDB-1:0]      cdb_value,
    output logic [XLEN-1:0]            val,
    output logic                       rdy,
    output logic [XLEN-1:0]            nxt_val,
    output logic                       nxt_rdy
);

    logic [XLEN-1:0]      val_q;
    logic                 rdy_q;
    logic [ROB_TAG_W-1:0] tag_q;

    logic [XLEN-1:0]      cur_val;
    logic                 cur_rdy;
    logic [ROB_TAG_W-1:0] cur_tag;
    logic                 hit;
    logic [XLEN-1:0]      hit_val;

    always_comb begin
        cur_val = load ? load_val : val_q;
        cur_rdy = load ? load_rdy : rdy_q;
        cur_tag = load ? load_tag : tag_q;
        hit     = 1'b0;
        hit_val = '0;
        // Walk downwards so the lowest matching port is the last to assign.
        for (int i = N_CDB - 1; i >= 0; i--) begin
            if ((load || snoop) && !cur_rdy && cdb_valid[i] &&
                cdb_rob_entry[i*ROB_TAG_W +: ROB_TAG_W] == cur_tag) begin
                hit     = 1'b1;
                hit_val = cdb_value[i*XLEN +: XLEN];
            end
        end
        nxt_rdy = cur_rdy | hit;
        nxt_val = hit ? hit_val : cur_val;
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            val_q <= '0;
            rdy_q <= 1'b0;
            tag_q <= '0;
        end else if (load || snoop) begin
            val_q <= nxt_val;
            rdy_q <= nxt_rdy;
            tag_q <= cur_tag;
        end
    end

    assign val = val_q;
    assign rdy = rdy_q;

endmodule

// File: rtl/reservation_station.sv
// Single-entry reservation station feeding the FU scheduler.
// Optional RS_WAKEUP_BYPASS_EN: zero-cycle wakeup on the last CDB capture.
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int N_CDB = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       issue_valid,
    output logic                       issue_ready,
    input  logic [ALU_OP_W-1:0]        issue_alu_op,
    input  logic [ROB_TAG_W-1:0]       issue_rob_entry,
    input  logic [BR_TYPE_W-1:0]       issue_branch_type,
    input  logic [XLEN-1:0]            issue_rs1_val,
    input  logic [XLEN-1:0]            issue_rs2_val,
    input  logic                       issue_rs1_rdy,
    input  logic                       issue_rs2_rdy,
    input  logic [ROB_TAG_W-1:0]       issue_rs1_tag,
    input  logic [ROB_TAG_W-1:0]       issue_rs2_tag,
    input  logic [N_CDB-1:0]           cdb_valid,
    input  logic [ROB_TAG_W*N_CDB-1:0] cdb_rob_entry,
    input  logic [XLEN*N_CDB-1:0]      cdb_value,
    input  logic                       consumed,
    output rs_out_t                    rs_data,
    output logic                       busy
);

    rs_state_t            state;
    logic [ALU_OP_W-1:0]  alu_op_q;
    logic [ROB_TAG_W-1:0] rob_q;
    logic [BR_TYPE_W-1:0] br_q;

    logic                 do_clear;
    logic                 do_load;
    logic                 do_snoop;
    logic                 both_nxt_rdy;

    logic [XLEN-1:0]      s1_val, s2_val, s1_nval, s2_nval;
    logic                 s1_rdy, s2_rdy, s1_nrdy, s2_nrdy;
    logic                 out_valid;

    assign do_clear     = flush || (state == READY && consumed);
    assign do_load      = !flush && state == EMPTY && issue_valid;
    assign do_snoop     = !flush && state == WAITING;
    assign both_nxt_rdy = s1_nrdy && s2_nrdy;

    rs_operand_slot #(.N_CDB(N_CDB)) u_rs1 (
        .clk           (clk),
        .reset         (reset),
        .clear         (do_clear),
        .load          (do_load),
        .snoop         (do_snoop),
        .load_val      (issue_rs1_val),
        .load_rdy      (issue_rs1_rdy),
        .load_tag      (issue_rs1_tag),
        .cdb_valid     (cdb_valid),
        .cdb_rob_entry (cdb_rob_entry),
        .cdb_value     (cdb_value),
        .val           (s1_val),
        .rdy           (s1_rdy),
        .nxt_val       (s1_nval),
        .nxt_rdy       (s1_nrdy)
    );

    rs_operand_slot #(.N_CDB(N_CDB)) u_rs2 (
        .clk           (clk),
        .reset         (reset),
        .clear         (do_clear),
        .load          (do_load),
        .snoop         (do_snoop),
        .load_val      (issue_rs2_val),
        .load_rdy      (issue_rs2_rdy),
        .load_tag      (issue_rs2_tag),
        .cdb_valid     (cdb_valid),
        .cdb_rob_entry (cdb_rob_entry),
        .cdb_value     (cdb_value),
        .val           (s2_val),
        .rdy           (s2_rdy),
        .nxt_val       (s2_nval),
        .nxt_rdy       (s2_nrdy)
    );

    always_ff @(posedge clk) begin
        if (reset || do_clear) begin
            state    <= EMPTY;
            alu_op_q <= '0;
            rob_q    <= '0;
            br_q     <= '0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (issue_valid) begin
                        alu_op_q <= issue_alu_op;
                        rob_q    <= issue_rob_entry;
                        br_q     <= issue_branch_type;
                        state    <= both_nxt_rdy ? READY : WAITING;
                    end
                end
                WAITING: begin
                    if (both_nxt_rdy)
                        state <= READY;
                end
                READY: begin
                    state <= READY;
                end
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef RS_WAKEUP_BYPASS_EN
    assign out_valid = state == READY ||
                       (state == WAITING && !flush && both_nxt_rdy);
`else
    assign out_valid = state == READY;
`endif

    // A not-yet-ready operand can only be visible through the bypass.
    always_comb begin
        rs_data = '0;
        if (out_valid) begin
            rs_data.valid_operands = 1'b1;
            rs_data.ALU_op         = alu_op_q;
            rs_data.ROB_entry      = rob_q;
            rs_data.branch_type    = br_q;
            rs_data.rs1            = s1_rdy ? s1_val : s1_nval;
            rs_data.rs2            = s2_rdy ? s2_val : s2_nval;
        end
    end

    assign issue_ready = state == EMPTY;
    assign busy        = state != EMPTY;

endmodule

// File: doc/reservation_station.md
# reservation_station

Single-entry reservation station: the producer side of the execute-stage scheduling interface. It accepts one renamed instruction from dispatch, snoops the common data bus (CDB) for outstanding source operands, and presents the entry to the functional-unit scheduler as an `rs_out_t`. When the scheduler returns `consumed`, the entry frees. Four instances feed the scheduler's four RS inputs.

## Interface
Parameters:
- `N_CDB`, default 2: number of CDB broadcast ports snooped.

Ports (reset is synchronous and active-high):
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `flush` in 1: mispredict squash; empties the entry.
- `issue_valid` in 1: dispatch presents an instruction.
- `issue_ready` out 1: entry can accept; equals `state == EMPTY`.
- `issue_alu_op` in 3: ALU op code, stored verbatim.
- `issue_rob_entry` in 4: destination ROB tag.
- `issue_branch_type` in 2: branch type, stored verbatim.
- `issue_rs1_val`, `issue_rs2_val` in 32 each: operand values, valid when the matching `_rdy` is 1.
- `issue_rs1_rdy`, `issue_rs2_rdy` in 1 each: operand already available.
- `issue_rs1_tag`, `issue_rs2_tag` in 4 each: producing ROB tag when not ready.
- `cdb_valid` in `N_CDB`: broadcast valid, one bit per port.
- `cdb_rob_entry` in `4*N_CDB`: broadcast ROB tag, port i at bits [4i+3:4i].
- `cdb_value` in `32*N_CDB`: broadcast value, port i at bits [32i+31:32i].
- `consumed` in 1: this RS's bit of the scheduler's consumed bus.
- `rs_data` out `rs_out_t`: fields `valid_operands`, `ALU_op`, `ROB_entry`, `branch_type`, `rs1`, `rs2`.
- `busy` out 1: `state != EMPTY`.

## Operation
- States: EMPTY, WAITING, READY.
- EMPTY:
  - When `issue_valid` is high, latch all issue fields.
  - Go to READY if both operands are ready after issue-cycle capture; otherwise go to WAITING.
- Issue-cycle capture: a not-ready operand whose tag matches any valid CDB port that same cycle takes the CDB value and is marked ready.
- WAITING:
  - Each not-ready operand compares its tag against every valid CDB port and captures on a match.
  - If more than one port matches, the lowest port index wins.
  - Ready operands ignore the CDB.
  - Go to READY when both operands are ready, counting captures made this cycle.
- READY:
  - `valid_operands` = 1; `rs_data` fields carry the stored entry.
  - `consumed` = 1 → EMPTY.
- `consumed` is ignored in EMPTY and WAITING.
- `issue_valid` is ignored when `issue_ready` = 0. Dispatch must hold the instruction until it is accepted.
- Output gating: when not READY, every `rs_data` field is 0.
- Priority (highest first): `reset`, `flush`, `consumed`, issue, CDB capture.
  - `flush` in the same cycle as `issue_valid` drops the issue.
  - `flush` in the same cycle as `consumed` ends in EMPTY.
- Reset mid-operation: entry discarded, state EMPTY, all stored fields cleared.

## Timing
- Reset values:
  - `rs_data` all fields 0.
  - `issue_ready` = 1.
  - `busy` = 0.
  - State EMPTY.
- Issue with both operands ready at edge t: `valid_operands` = 1 from t+1.
- Last CDB match at cycle t: `valid_operands` = 1 from t+1 (default build).
- `consumed` sampled high at edge t: `valid_operands` = 0 and `issue_ready` = 1 from t+1.
- A new issue can be accepted at edge t+1 at the earliest.
- Minimum back-to-back occupancy is 2 cycles per instruction.
- No combinational path from `consumed` to any output.

## Configuration
- `RS_WAKEUP_BYPASS_EN` defined:
  - In WAITING, when the CDB supplies the last missing operand, `valid_operands` and the captured value are driven combinationally in that same cycle.
  - The state still registers to READY at the edge.
  - Wakeup latency is 0 cycles.
  - `consumed` in a bypass cycle is not possible, because the scheduler's consumed bus is registered.
- Undefined: outputs come from registered state only; wakeup latency is 1 cycle.

## Structure
- Shared package `structs.svh`:
  - `rs_out_t` (existing).
  - New `rs_state_t` enum.
  - `ROB_TAG_W` = 4, `XLEN` = 32.
- Sub-module `rs_operand_slot`, instantiated twice. Each instance holds value, ready bit and tag, and performs the `N_CDB`-way tag compare and capture.
  - Inputs: `load`, load value/ready/tag, CDB buses, `clear`.
  - Outputs: `val`, `rdy`, and a combinational next-ready / next-value pair for the bypass.

## Test plan
- Reset, then idle → `rs_data` = 0, `issue_ready` = 1, `busy` = 0.
- Issue `ALU_op` = 3'b100, ROB 5, `rs1` = 0x10 ready, `rs2` = 0x20 ready → cycle +1: `valid_operands` = 1, `rs1` = 0x10, `rs2` = 0x20, `ROB_entry` = 5. `consumed` pulse → cycle +1: EMPTY.
- Issue with `rs2` tag 7 not ready. CDB port 1 broadcasts tag 7 = 0xDEAD three cycles later → `rs2` = 0xDEAD, `valid_operands` from the following cycle; with `RS_WAKEUP_BYPASS_EN`, in the same cycle.
- Issue with `rs1` tag 3 while CDB port 0 broadcasts tag 3 = 0x55 in the same cycle → entry goes straight to READY with `rs1` = 0x55.
- Both CDB ports broadcast tag 2 (0x1 on port 0, 0x2 on port 1) to a waiting operand with tag 2 → captures 0x1.
- `flush` together with `issue_valid`, and `flush` together with `consumed` → both end EMPTY with `rs_data` = 0. `consumed` while WAITING → no state change.
